// File: rtl/eca_row_sequencer.sv
// eca_row_sequencer: holds one CA row and updates it serially, one cell per cycle, through an external rule stage.
// Optional macro ECA_WRAP_EN selects a periodic boundary; otherwise out-of-range neighbours read as 0.
module eca_row_sequencer #(
    parameter int WIDTH = 8,
    parameter int GW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [GW-1:0]    gens,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] row,
    output logic             rule_in1,
    output logic             rule_in2,
    output logic             rule_in3,
    input  logic             rule_out
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, FINISH} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] row_q, row_d, next_q, next_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [GW-1:0]    gen_left_q, gen_left_d;
    logic [WIDTH+1:0] ext, win;

    // ext[0] is cell[-1], ext[WIDTH+1] is cell[WIDTH]; the window starting at idx is {left, centre, right}
`ifdef ECA_WRAP_EN
    assign ext = {row_q[0], row_q, row_q[WIDTH-1]};
`else
    assign ext = {1'b0, row_q, 1'b0};
`endif
    assign win = ext >> idx_q;

    assign busy     = state_q != IDLE;
    assign done     = state_q == FINISH;
    assign row      = row_q;
    assign rule_in1 = (state_q == SCAN) ? win[2] : 1'b0;
    assign rule_in2 = (state_q == SCAN) ? win[1] : 1'b0;
    assign rule_in3 = (state_q == SCAN) ? win[0] : 1'b0;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        next_d     = next_q;
        idx_d      = idx_q;
        gen_left_d = gen_left_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    row_d = seed;
                end else if (start) begin
                    if (gens == '0) begin
                        state_d = FINISH;
                    end else begin
                        gen_left_d = gens;
                        idx_d      = '0;
                        state_d    = SCAN;
                    end
                end
            end
            SCAN: begin
                next_d[idx_q] = rule_out;
                idx_d         = idx_q + 1'b1;
                state_d       = (idx_q == LAST) ? COMMIT : SCAN;
            end
            COMMIT: begin
                row_d      = next_q;
                gen_left_d = gen_left_q - 1'b1;
                idx_d      = '0;
                state_d    = (gen_left_q == GW'(1)) ? FINISH : SCAN;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            next_q     <= '0;
            idx_q      <= '0;
            gen_left_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            next_q     <= next_d;
            idx_q      <= idx_d;
            gen_left_q <= gen_left_d;
        end
    end
endmodule
